addition_map_sequencer: RTL and testbench

ADDITION_MAP_SEQUENCER -- requirements
Module: addition_map_sequencer

---
 rtl/addition_map_seq_pkg.sv | 18 +
 rtl/addition_map_sequencer_if.sv | 40 ++++
 rtl/addition_map_cond_eval.sv | 25 ++
 rtl/addition_map_sequencer.sv | 149 ++++++++++++++
 tb/tb_addition_map_sequencer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/addition_map_seq_pkg.sv
// Shared definitions for the addition-map sequencer: FSM state codes,
// condition-select encoding and the default word-store depth.
// Optional feature macro: ADDITION_MAP_SEQ_BOUNDS_CHECK_EN (see top).
package addition_map_seq_pkg;

    localparam int DEPTH_DEFAULT = 64;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Condition select: 0 always runs, 1..NFLAGS pick a flag, rest never run
    localparam logic [3:0] COND_ALWAYS = 4'd0;

endpackage

// File: rtl/addition_map_sequencer_if.sv
// Command, word-store and status bundle for the addition-map sequencer.
// slave: the sequencer side; master: the command issuer / store side.
interface addition_map_sequencer_if #(
    parameter int AW     = 6,
    parameter int NFLAGS = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [31:0]       cmd_origin;
    logic [31:0]       cmd_modifier;
    logic [31:0]       cmd_length;
    logic [3:0]        cmd_cond_sel;
    logic [NFLAGS-1:0] flags;
    logic [AW-1:0]     rd_addr_a;
    logic [AW-1:0]     rd_addr_b;
    logic [31:0]       rd_data_a;
    logic [31:0]       rd_data_b;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              skipped;
    logic              err;

    modport slave (
        input  cmd_valid, cmd_origin, cmd_modifier, cmd_length, cmd_cond_sel,
               flags, rd_data_a, rd_data_b,
        output cmd_ready, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
               busy, done, skipped, err
    );

    modport master (
        output cmd_valid, cmd_origin, cmd_modifier, cmd_length, cmd_cond_sel,
               flags, rd_data_a, rd_data_b,
        input  cmd_ready, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
               busy, done, skipped, err
    );

endinterface

// File: rtl/addition_map_cond_eval.sv
// Condition evaluator: turns a condition select plus the flag vector into
// a single execute bit. Purely combinational.
module addition_map_cond_eval
    import addition_map_seq_pkg::*;
#(
    parameter int NFLAGS = 8
) (
    input  logic [3:0]        cond_sel_i,
    input  logic [NFLAGS-1:0] flags_i,
    output logic              exec_o
);

    // Select 0 always runs; k in 1..NFLAGS follows flags[k-1]; others never run
    always_comb begin
        exec_o = 1'b0;
        if (cond_sel_i == COND_ALWAYS) begin
            exec_o = 1'b1;
        end else begin
            for (int k = 1; k <= NFLAGS; k++) begin
                if (cond_sel_i == 4'(k)) exec_o = flags_i[k-1];
            end
        end
    end

endmodule

// File: rtl/addition_map_sequencer.sv
// Addition-map sequencer: mem[origin+i] += mem[modifier+i] for i in
// 0..length-1, two cycles per element, iterating downwards when the
// source range overlaps the destination from below.
// Optional: define ADDITION_MAP_SEQ_BOUNDS_CHECK_EN to reject commands whose
// ranges run past DEPTH (err=1) instead of wrapping addresses.
module addition_map_sequencer
    import addition_map_seq_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int AW     = $clog2(DEPTH),
    parameter int NFLAGS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    addition_map_sequencer_if.slave  bus
);

    logic [2:0]  state_q,    state_d;
    logic [31:0] origin_q,   origin_d;
    logic [31:0] modifier_q, modifier_d;
    logic [31:0] length_q,   length_d;
    logic [31:0] idx_q,      idx_d;
    logic        cond_q,     cond_d;
    logic        desc_q,     desc_d;
    logic        skipped_q,  skipped_d;
    logic        cond_exec;
    logic        overlap;
    logic        last_elem;
    logic        range_bad;

    addition_map_cond_eval #(.NFLAGS(NFLAGS)) u_cond (
        .cond_sel_i (bus.cmd_cond_sel),
        .flags_i    (bus.flags),
        .exec_o     (cond_exec)
    );

    // Source starts below destination and reaches into it: walk downwards so
    // every B read sees the value from before this command.
    assign overlap = (modifier_q < origin_q) &&
                     (({1'b0, modifier_q} + {1'b0, length_q}) > {1'b0, origin_q});
    assign last_elem = desc_q ? (idx_q == 32'd0) : (idx_q == length_q - 32'd1);

`ifdef ADDITION_MAP_SEQ_BOUNDS_CHECK_EN
    logic err_q, err_d;
    assign range_bad = (({1'b0, origin_q}   + {1'b0, length_q}) > 33'(DEPTH)) ||
                       (({1'b0, modifier_q} + {1'b0, length_q}) > 33'(DEPTH));
    assign bus.err   = err_q && (state_q == ST_DONE) && !rst;
`else
    assign range_bad = 1'b0;
    assign bus.err   = 1'b0;
`endif

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        origin_d   = origin_q;
        modifier_d = modifier_q;
        length_d   = length_q;
        idx_d      = idx_q;
        cond_d     = cond_q;
        desc_d     = desc_q;
        skipped_d  = skipped_q;
`ifdef ADDITION_MAP_SEQ_BOUNDS_CHECK_EN
        err_d      = err_q;
`endif
        case (state_q)
            ST_IDLE: if (bus.cmd_valid) begin
                origin_d   = bus.cmd_origin;
                modifier_d = bus.cmd_modifier;
                length_d   = bus.cmd_length;
                cond_d     = cond_exec;
                skipped_d  = 1'b0;
`ifdef ADDITION_MAP_SEQ_BOUNDS_CHECK_EN
                err_d      = 1'b0;
`endif
                state_d    = ST_CHECK;
            end
            ST_CHECK: begin
                if (!cond_q) begin
                    skipped_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (range_bad) begin
`ifdef ADDITION_MAP_SEQ_BOUNDS_CHECK_EN
                    err_d     = 1'b1;
`endif
                    state_d   = ST_DONE;
                end else if (length_q == 32'd0) begin
                    state_d   = ST_DONE;
                end else begin
                    desc_d    = overlap;
                    idx_d     = overlap ? length_q - 32'd1 : 32'd0;
                    state_d   = ST_READ;
                end
            end
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: begin
                if (last_elem) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = desc_q ? idx_q - 32'd1 : idx_q + 32'd1;
                    state_d = ST_READ;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and command registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            origin_q   <= '0;
            modifier_q <= '0;
            length_q   <= '0;
            idx_q      <= '0;
            cond_q     <= 1'b0;
            desc_q     <= 1'b0;
            skipped_q  <= 1'b0;
`ifdef ADDITION_MAP_SEQ_BOUNDS_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            origin_q   <= origin_d;
            modifier_q <= modifier_d;
            length_q   <= length_d;
            idx_q      <= idx_d;
            cond_q     <= cond_d;
            desc_q     <= desc_d;
            skipped_q  <= skipped_d;
`ifdef ADDITION_MAP_SEQ_BOUNDS_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    // Store port and status; rst kills the in-flight write and done pulse
    assign bus.rd_addr_a = origin_q[AW-1:0]   + idx_q[AW-1:0];
    assign bus.rd_addr_b = modifier_q[AW-1:0] + idx_q[AW-1:0];
    assign bus.wr_addr   = origin_q[AW-1:0]   + idx_q[AW-1:0];
    assign bus.wr_data   = bus.rd_data_a + bus.rd_data_b;
    assign bus.wr_en     = (state_q == ST_WRITE) && !rst;
    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE) && !rst;
    assign bus.skipped   = skipped_q && (state_q == ST_DONE) && !rst;

endmodule

// File: tb/tb_addition_map_sequencer.sv
// Scoreboarded bench for addition_map_sequencer: directed commands push the
// expected completion into a queue, a monitor pops and compares on done.
module tb_addition_map_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    addition_map_sequencer_if #(.AW(6), .NFLAGS(8)) bus ();

    addition_map_sequencer #(.DEPTH(64), .AW(6), .NFLAGS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic skipped;
        logic err;
        int   lat;
        int   nwr;
        int   acc;
        int   wbase;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          n_done = 0;
    logic [31:0] mem [0:63];
    logic [5:0]  wlog [0:1023];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_a = '0;
    logic [31:0] pl_d = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Word store model: one-cycle read latency, write port, preload port
    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.rd_data_a <= mem[bus.rd_addr_a];
        bus.rd_data_b <= mem[bus.rd_addr_b];
        if (pl_en) mem[pl_a] <= pl_d;
        if (bus.wr_en) begin
            mem[bus.wr_addr]   <= bus.wr_data;
            wlog[wr_cnt[9:0]]  <= bus.wr_addr;
            wr_cnt             <= wr_cnt + 1;
        end
    end

    // Monitor: compare each done pulse against the oldest expectation
    always @(negedge clk) begin
        if (bus.done) begin
            n_done <= n_done + 1;
            if (exp_q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("skipped", 32'(bus.skipped), 32'(e.skipped));
                chk("err", 32'(bus.err), 32'(e.err));
                chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                chk("write_count", 32'(wr_cnt - e.wbase), 32'(e.nwr));
            end
        end
    end

    task automatic pl(input int a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_a = 6'(a); pl_d = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic issue(input int o, input int m, input int l, input int c,
                         input logic [7:0] f, input logic sk, input logic er,
                         input int lat, input int nwr);
        exp_t e;
        int   guard;
        int   target;
        @(negedge clk);
        guard = 0;
        while (!bus.cmd_ready && guard < 100) begin @(negedge clk); guard++; end
        if (!bus.cmd_ready) chk("ready_timeout", 32'd0, 32'd1);
        bus.cmd_origin = 32'(o); bus.cmd_modifier = 32'(m); bus.cmd_length = 32'(l);
        bus.cmd_cond_sel = 4'(c); bus.flags = f; bus.cmd_valid = 1'b1;
        e.skipped = sk; e.err = er; e.lat = lat; e.nwr = nwr;
        e.acc = cyc; e.wbase = wr_cnt;
        target = n_done + 1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        guard = 0;
        while (n_done < target && guard < 200) begin @(negedge clk); guard++; end
        if (n_done < target) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int base;
        int seen;
        int dn;
        bus.cmd_valid = 1'b0; bus.cmd_origin = '0; bus.cmd_modifier = '0;
        bus.cmd_length = '0; bus.cmd_cond_sel = '0; bus.flags = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_skipped", 32'(bus.skipped), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);

        // Basic element-wise add
        pl(0, 1); pl(1, 2); pl(2, 3); pl(3, 4);
        pl(8, 10); pl(9, 20); pl(10, 30); pl(11, 40);
        issue(0, 8, 4, 0, 8'h00, 1'b0, 1'b0, 10, 4);
        chk("add_m0", mem[0], 32'd11); chk("add_m1", mem[1], 32'd22);
        chk("add_m2", mem[2], 32'd33); chk("add_m3", mem[3], 32'd44);

        // Overlapping ranges run descending
        pl(4, 1); pl(5, 1); pl(6, 1); pl(7, 1);
        base = wr_cnt;
        issue(5, 4, 3, 0, 8'h00, 1'b0, 1'b0, 8, 3);
        chk("ovl_m5", mem[5], 32'd2); chk("ovl_m6", mem[6], 32'd2);
        chk("ovl_m7", mem[7], 32'd2);
        chk("ovl_order0", 32'(wlog[base[9:0]]), 32'd7);
        chk("ovl_order2", 32'(wlog[10'(base + 2)]), 32'd5);

        // Condition false: skipped, no writes
        issue(0, 8, 4, 3, 8'h00, 1'b1, 1'b0, 2, 0);
        chk("skip_m0", mem[0], 32'd11);

        // Flag-selected execution, out-of-range select, zero length
        pl(20, 7); pl(24, 8);
        issue(20, 24, 1, 2, 8'h02, 1'b0, 1'b0, 4, 1);
        chk("flag_m20", mem[20], 32'd15);
        issue(20, 24, 1, 9, 8'hFF, 1'b1, 1'b0, 2, 0);
        issue(20, 24, 0, 0, 8'h00, 1'b0, 1'b0, 2, 0);
        chk("len0_m20", mem[20], 32'd15);

        // Carry discarded
        pl(0, 32'hFFFF_FFFF); pl(1, 2);
        issue(0, 1, 1, 0, 8'h00, 1'b0, 1'b0, 4, 1);
        chk("wrap_m0", mem[0], 32'd1);

        // Range past DEPTH
        pl(62, 5); pl(63, 6); pl(0, 100); pl(1, 200); pl(2, 300); pl(3, 400);
        base = wr_cnt;
`ifdef ADDITION_MAP_SEQ_BOUNDS_CHECK_EN
        issue(62, 0, 4, 0, 8'h00, 1'b0, 1'b1, 2, 0);
        chk("oob_m62", mem[62], 32'd5);
`else
        issue(62, 0, 4, 0, 8'h00, 1'b0, 1'b0, 10, 4);
        chk("oob_m62", mem[62], 32'd105); chk("oob_m63", mem[63], 32'd206);
        chk("oob_m0", mem[0], 32'd400);   chk("oob_m1", mem[1], 32'd600);
        chk("oob_addr2", 32'(wlog[10'(base + 2)]), 32'd0);
`endif

        // Reset during the third write of an 8-element command
        @(negedge clk);
        bus.cmd_origin = 32'd16; bus.cmd_modifier = 32'd32; bus.cmd_length = 32'd8;
        bus.cmd_cond_sel = 4'd0; bus.cmd_valid = 1'b1;
        base = wr_cnt; dn = n_done;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 40 && seen < 3; k++) begin
            @(negedge clk);
            if (bus.wr_en) seen++;
        end
        chk("rst_mid_reach", 32'(seen), 32'd3);
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        repeat (20) @(negedge clk);
        chk("abort_writes", 32'(wr_cnt - base), 32'd2);
        chk("abort_no_done", 32'(n_done - dn), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
